// File: rtl/uart_sender_core.sv
// uart_sender_core: button-triggered three-byte UART frame sender with a one-byte reply receiver.
// Define UART_PARITY_EN for 8E1 framing on both directions (default build is 8N1).

module uart_sender_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_line,
    output logic       tx_done
);
`ifdef UART_PARITY_EN
    localparam int NBITS = 10;
`else
    localparam int NBITS = 9;
`endif
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

    logic             busy;
    logic [CW-1:0]    clk_cnt;
    logic [3:0]       bits_left;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] frame;

    // Bits that follow the start bit, shifted out LSB first; the stop bit is the MSB.
`ifdef UART_PARITY_EN
    assign frame = {1'b1, ^tx_byte, tx_byte};
`else
    assign frame = {1'b1, tx_byte};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            clk_cnt   <= '0;
            bits_left <= '0;
            shreg     <= '0;
            tx_line   <= 1'b1;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!busy) begin
                if (tx_start) begin
                    busy      <= 1'b1;
                    clk_cnt   <= '0;
                    bits_left <= 4'(NBITS);
                    shreg     <= frame;
                    tx_line   <= 1'b0;
                end
            end else begin
                // Raised one cycle early so it is high during the last stop-bit cycle.
                tx_done <= (bits_left == 4'd0) && (clk_cnt == PRE_LAST);
                if (clk_cnt == LAST) begin
                    clk_cnt <= '0;
                    if (bits_left == 4'd0) begin
                        busy <= 1'b0;
                    end else begin
                        tx_line   <= shreg[0];
                        shreg     <= {1'b1, shreg[NBITS-1:1]};
                        bits_left <= bits_left - 4'd1;
                    end
                end else begin
                    clk_cnt <= clk_cnt + CW'(1);
                end
            end
        end
    end
endmodule

module uart_sender_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_sync,
    output logic [7:0] rx_data,
    output logic       rx_error,
    output logic       rx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_STOP   = 3'd3,
        RX_DONE   = 3'd4,
        RX_PARITY = 3'd5
    } rx_state_t;

    rx_state_t     state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          parity_ok;

    assign rx_done = (state == RX_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            parity_ok <= 1'b1;
            rx_data   <= '0;
            rx_error  <= 1'b0;
        end else begin
            case (state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        state   <= RX_START;
                        clk_cnt <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is gone by mid-bit was a glitch.
                    if (clk_cnt == HALF) begin
                        clk_cnt   <= '0;
                        bit_idx   <= '0;
                        parity_ok <= 1'b1;
                        state     <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            state <= RX_PARITY;
`else
                            state <= RX_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`ifdef UART_PARITY_EN
                RX_PARITY: begin
                    if (clk_cnt == LAST) begin
                        clk_cnt   <= '0;
                        parity_ok <= (rx_sync == ^shreg);
                        state     <= RX_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
`endif
                RX_STOP: begin
                    // Bad frames skip DONE so the sequencer keeps waiting for a real reply.
                    if (clk_cnt == LAST) begin
                        clk_cnt <= '0;
                        if (rx_sync && parity_ok) begin
                            rx_data <= shreg;
                            state   <= RX_DONE;
                        end else begin
                            rx_error <= 1'b1;
                            state    <= RX_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                RX_DONE: state <= RX_IDLE;
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

module uart_sender_uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    input  logic       rx_sync,
    output logic       tx_line,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_error,
    output logic       rx_done
);
    uart_sender_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) txInst (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_byte  (tx_byte),
        .tx_line  (tx_line),
        .tx_done  (tx_done)
    );

    uart_sender_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) rxInst (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_sync  (rx_sync),
        .rx_data  (rx_data),
        .rx_error (rx_error),
        .rx_done  (rx_done)
    );
endmodule

module uart_sender_core #(
    parameter int         CLKS_PER_BIT = 434,
    parameter logic [7:0] HEADER       = 8'hA5
) (
    input  logic        CLOCK_50,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    inout  wire  [35:0] GPIO,
    output logic [9:0]  LEDR
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_HDR  = 3'd1,
        SEND_HDR  = 3'd2,
        LOAD_DATA = 3'd3,
        SEND_DATA = 3'd4,
        LOAD_CSUM = 3'd5,
        SEND_CSUM = 3'd6,
        WAIT_RX   = 3'd7
    } seq_state_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] key_meta;
    logic [1:0] rx_meta;
    seq_state_t is_state;
    logic [7:0] payload;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_line;
    logic       tx_done;
    logic [7:0] rx_data;
    logic       rx_error;
    logic       rx_done;
    logic       unused_inputs;

    assign clk           = CLOCK_50;
    assign rst_n         = KEY[0];
    assign unused_inputs = ^{KEY[3], KEY[1], SW[9:8]};

    // Both idle levels are high, so the synchronizers reset high to avoid a spurious start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 2'b11;
            rx_meta  <= 2'b11;
        end else begin
            key_meta <= {key_meta[0], KEY[2]};
            rx_meta  <= {rx_meta[0], GPIO[1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_state <= IDLE;
            payload  <= '0;
        end else begin
            case (is_state)
                IDLE:      if (!key_meta[1]) is_state <= LOAD_HDR;
                LOAD_HDR:  is_state <= SEND_HDR;
                SEND_HDR:  if (tx_done) is_state <= LOAD_DATA;
                LOAD_DATA: begin
                    payload  <= SW[7:0];
                    is_state <= SEND_DATA;
                end
                SEND_DATA: if (tx_done) is_state <= LOAD_CSUM;
                LOAD_CSUM: is_state <= SEND_CSUM;
                SEND_CSUM: if (tx_done) is_state <= WAIT_RX;
                WAIT_RX:   if (rx_done) is_state <= IDLE;
                default:   is_state <= IDLE;
            endcase
        end
    end

    // The checksum reuses the payload latched in LOAD_DATA so it always matches the sent byte.
    always_comb begin
        tx_start = 1'b0;
        tx_byte  = HEADER;
        case (is_state)
            LOAD_HDR: begin
                tx_start = 1'b1;
                tx_byte  = HEADER;
            end
            LOAD_DATA: begin
                tx_start = 1'b1;
                tx_byte  = SW[7:0];
            end
            LOAD_CSUM: begin
                tx_start = 1'b1;
                tx_byte  = HEADER ^ payload;
            end
            default: begin
                tx_start = 1'b0;
                tx_byte  = HEADER;
            end
        endcase
    end

    uart_sender_uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) uart (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_start (tx_start),
        .tx_byte  (tx_byte),
        .rx_sync  (rx_meta[1]),
        .tx_line  (tx_line),
        .tx_done  (tx_done),
        .rx_data  (rx_data),
        .rx_error (rx_error),
        .rx_done  (rx_done)
    );

    assign GPIO[0]    = tx_line;
    assign GPIO[35:2] = {34{1'bz}};
    assign LEDR       = {(is_state != IDLE) && (is_state != WAIT_RX), rx_error, rx_data};
endmodule

// File: tb/tb_uart_sender_core.sv
// Directed self-checking bench for uart_sender_core (8N1 build, CLKS_PER_BIT = 8).

module tb_uart_sender_core;
    localparam int CPB = 8;

    logic        clock_50 = 1'b0;
    logic [3:0]  key;
    logic [9:0]  sw;
    logic        rx_line;
    wire  [35:0] gpio;
    logic [9:0]  ledr;
    int          checks = 0;
    int          errors = 0;

    assign gpio[1] = rx_line;

    always #5 clock_50 = ~clock_50;

    uart_sender_core #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
        .CLOCK_50 (clock_50),
        .KEY      (key),
        .SW       (sw),
        .GPIO     (gpio),
        .LEDR     (ledr)
    );

    // Expected TX waveform: one sample per clock, start bit first, each bit CPB samples long.
    function automatic logic [79:0] expand_byte(input logic [7:0] b);
        logic [9:0]  fr;
        logic [79:0] r;
        fr = {1'b1, b, 1'b0};
        for (int i = 0; i < 80; i++) r[i] = fr[i / CPB];
        return r;
    endfunction

    task automatic capture_byte(output logic [79:0] cap);
        for (int i = 0; i < 80; i++) begin
            @(negedge clock_50);
            cap[i] = gpio[0];
        end
    endtask

    // Drives one serial frame on RX starting at the current negedge; reports when START was seen.
    task automatic send_rx_byte(input logic [7:0] b, input logic stop_bit, output int start_seen);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        start_seen = -1;
        for (int k = 0; k < 10; k++) begin
            rx_line = fr[k];
            for (int j = 1; j <= CPB; j++) begin
                @(negedge clock_50);
                if (k == 0 && start_seen < 0 && dut.uart.rxInst.state == 3'd1) start_seen = j;
            end
        end
        rx_line = 1'b1;
    endtask

    task automatic test_reset;
        key[0] = 1'b0;
        repeat (3) @(negedge clock_50);
        checks++;
        if (gpio[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_tx: got %b expected 1", gpio[0]);
        end
        checks++;
        if (dut.is_state !== 3'd0) begin
            errors++; $display("[TB] FAIL reset_is_state: got %0d expected 0", dut.is_state);
        end
        checks++;
        if (dut.uart.rxInst.state !== 3'd0) begin
            errors++; $display("[TB] FAIL reset_rx_state: got %0d expected 0", dut.uart.rxInst.state);
        end
        checks++;
        if (ledr !== 10'h000) begin
            errors++; $display("[TB] FAIL reset_ledr: got %h expected 000", ledr);
        end
        key[0] = 1'b1;
        repeat (2) @(negedge clock_50);
    endtask

    task automatic test_send;
        logic [79:0] cap;
        logic [7:0]  exp_bytes [3];
        exp_bytes[0] = 8'hA5;
        exp_bytes[1] = 8'h08;
        exp_bytes[2] = 8'hAD;
        sw = 10'h008;
        key[2] = 1'b0;
        repeat (3) @(negedge clock_50);
        checks++;
        if (dut.is_state !== 3'd1) begin
            errors++; $display("[TB] FAIL start_load_hdr: got %0d expected 1", dut.is_state);
        end
        checks++;
        if (gpio[0] !== 1'b1) begin
            errors++; $display("[TB] FAIL start_tx_early: got %b expected 1", gpio[0]);
        end
        checks++;
        if (ledr[9] !== 1'b1) begin
            errors++; $display("[TB] FAIL busy_led: got %b expected 1", ledr[9]);
        end
        key[2] = 1'b1;
        for (int n = 0; n < 3; n++) begin
            capture_byte(cap);
            checks++;
            if (cap !== expand_byte(exp_bytes[n])) begin
                errors++;
                $display("[TB] FAIL tx_byte%0d: got %h expected %h", n, cap, expand_byte(exp_bytes[n]));
            end
            if (n < 2) begin
                @(negedge clock_50);
                checks++;
                if (dut.is_state !== 3'(3 + 2 * n)) begin
                    errors++;
                    $display("[TB] FAIL gap_state%0d: got %0d expected %0d", n, dut.is_state, 3 + 2 * n);
                end
            end
        end
        @(negedge clock_50);
        checks++;
        if (dut.is_state !== 3'd7) begin
            errors++; $display("[TB] FAIL wait_rx_state: got %0d expected 7", dut.is_state);
        end
        checks++;
        if (ledr[9] !== 1'b0) begin
            errors++; $display("[TB] FAIL busy_after_frame: got %b expected 0", ledr[9]);
        end
    endtask

    task automatic test_glitch;
        logic saw_start;
        logic saw_data;
        saw_start = 1'b0;
        saw_data  = 1'b0;
        rx_line = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clock_50);
            if (j == 2) rx_line = 1'b1;
            if (dut.uart.rxInst.state == 3'd1) saw_start = 1'b1;
            if (dut.uart.rxInst.state == 3'd2) saw_data = 1'b1;
        end
        checks++;
        if (saw_start !== 1'b1 || saw_data !== 1'b0) begin
            errors++; $display("[TB] FAIL glitch_path: start %b data %b expected start 1 data 0", saw_start, saw_data);
        end
        checks++;
        if (dut.uart.rxInst.state !== 3'd0) begin
            errors++; $display("[TB] FAIL glitch_rx_idle: got %0d expected 0", dut.uart.rxInst.state);
        end
        checks++;
        if (ledr !== 10'h000) begin
            errors++; $display("[TB] FAIL glitch_ledr: got %h expected 000", ledr);
        end
        checks++;
        if (dut.is_state !== 3'd7) begin
            errors++; $display("[TB] FAIL glitch_is_state: got %0d expected 7", dut.is_state);
        end
    endtask

    task automatic test_framing_error;
        int seen;
        send_rx_byte(8'h3C, 1'b0, seen);
        repeat (20) @(negedge clock_50);
        checks++;
        if (ledr !== 10'h100) begin
            errors++; $display("[TB] FAIL framing_ledr: got %h expected 100", ledr);
        end
        checks++;
        if (dut.is_state !== 3'd7) begin
            errors++; $display("[TB] FAIL framing_is_state: got %0d expected 7", dut.is_state);
        end
        checks++;
        if (dut.uart.rxInst.state !== 3'd0) begin
            errors++; $display("[TB] FAIL framing_rx_idle: got %0d expected 0", dut.uart.rxInst.state);
        end
    endtask

    task automatic test_reply;
        int seen;
        key[2] = 1'b0;
        repeat (4) @(negedge clock_50);
        send_rx_byte(8'h06, 1'b1, seen);
        checks++;
        if (seen < 2 || seen > 3) begin
            errors++; $display("[TB] FAIL rx_start_latency: got %0d expected 2..3", seen);
        end
        checks++;
        if (ledr !== 10'h106) begin
            errors++; $display("[TB] FAIL reply_ledr: got %h expected 106", ledr);
        end
        checks++;
        if (dut.is_state !== 3'd0) begin
            errors++; $display("[TB] FAIL reply_is_state: got %0d expected 0", dut.is_state);
        end
        checks++;
        if (dut.uart.rxInst.state !== 3'd0) begin
            errors++; $display("[TB] FAIL reply_rx_idle: got %0d expected 0", dut.uart.rxInst.state);
        end
        @(negedge clock_50);
        checks++;
        if (dut.is_state !== 3'd1) begin
            errors++; $display("[TB] FAIL restart_is_state: got %0d expected 1", dut.is_state);
        end
    endtask

    task automatic test_mid_frame_reset;
        logic found;
        logic low_seen;
        logic moved;
        found = 1'b0;
        key[2] = 1'b1;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clock_50);
            if (dut.is_state == 3'd4) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("[TB] FAIL send_data_timeout: got no state 4 expected state 4");
        end else begin
            repeat (3) @(negedge clock_50);
            checks++;
            if (gpio[0] !== 1'b0) begin
                errors++; $display("[TB] FAIL tx_low_before_reset: got %b expected 0", gpio[0]);
            end
            #2 key[0] = 1'b0;
            #1;
            checks++;
            if (gpio[0] !== 1'b1) begin
                errors++; $display("[TB] FAIL async_reset_tx: got %b expected 1", gpio[0]);
            end
            checks++;
            if (dut.is_state !== 3'd0) begin
                errors++; $display("[TB] FAIL async_reset_state: got %0d expected 0", dut.is_state);
            end
            @(negedge clock_50);
            key[0] = 1'b1;
            low_seen = 1'b0;
            moved    = 1'b0;
            repeat (200) begin
                @(negedge clock_50);
                if (gpio[0] !== 1'b1) low_seen = 1'b1;
                if (dut.is_state != 3'd0) moved = 1'b1;
            end
            checks++;
            if (low_seen !== 1'b0 || moved !== 1'b0) begin
                errors++; $display("[TB] FAIL quiet_after_reset: tx_low %b moved %b expected 0 0", low_seen, moved);
            end
        end
    endtask

    initial begin
        key     = 4'b1110;
        sw      = 10'h008;
        rx_line = 1'b1;
        test_reset;
        test_send;
        test_glitch;
        test_framing_error;
        test_reply;
        test_mid_frame_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_sender_core.md
# uart_sender_core

Button-triggered UART frame transmitter with a reply receiver, used as the serial link between the DE1-SoC board and the external door-monitor host. On a start request it sends a fixed three-byte frame (header, switch value, checksum) on a GPIO pin, then waits for a one-byte reply on another GPIO pin. The reply is shown on the LEDs. The block contains a top-level sequencer (`is_state`) plus an internal `uart` instance with a transmitter and a receiver (`rxInst`).

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Minimum 4.
- `HEADER`, default 8'hA5: first byte of every frame.

Ports (clock and reset first):
- `CLOCK_50` in 1: system clock. All logic uses the rising edge.
- `KEY[0]` in 1: reset. One clock; reset is asynchronous and active-low.
- `KEY[2]` in 1: start request, active-low, level-sensitive.
- `KEY[3:1]` (other bits) in: unused.
- `SW` in 10: `SW[7:0]` is the payload byte. `SW[9:8]` are ignored.
- `GPIO` inout 36:
  - `GPIO[0]` is TX, driven by the block.
  - `GPIO[1]` is RX, input.
  - All other bits are high-Z.
- `LEDR` out 10:
  - `[7:0]` last valid received byte.
  - `[8]` sticky receive error.
  - `[9]` busy, high when `is_state` is neither 0 nor 7.

## Operation
- `KEY[2]` and RX each pass through a 2-flop synchronizer.
- `is_state` is 3 bits:
  - 0 IDLE
  - 1 LOAD_HDR
  - 2 SEND_HDR
  - 3 LOAD_DATA
  - 4 SEND_DATA
  - 5 LOAD_CSUM
  - 6 SEND_CSUM
  - 7 WAIT_RX
- Transitions:
  - IDLE → LOAD_HDR when the synchronized `KEY[2]` is 0.
  - Each LOAD_x state lasts one cycle. It pulses `tx_start` with the byte and goes to SEND_x.
  - Each SEND_x state waits for `tx_done`, then moves to the next state. SEND_CSUM goes to WAIT_RX.
  - WAIT_RX → IDLE on `rx_done`. If `KEY[2]` is still held low, a new frame starts.
  - WAIT_RX has no timeout; only reset or a reply exits it.
- Frame bytes: `HEADER`, then `SW[7:0]` sampled in LOAD_DATA, then checksum = `HEADER ^ SW[7:0]`.
- TX format: 8N1, LSB first.
  - Line idles high.
  - Start bit 0, 8 data bits, stop bit 1, each `CLKS_PER_BIT` cycles long.
  - `tx_done` is a one-cycle pulse on the last cycle of the stop bit.
- RX `uart.rxInst.state` is 3 bits:
  - 0 IDLE
  - 1 START
  - 2 DATA
  - 3 STOP
  - 4 DONE
- RX transitions:
  - IDLE → START when the synchronized RX is 0.
  - START: at `CLKS_PER_BIT/2` cycles, RX still 0 → DATA; otherwise → IDLE (glitch rejected).
  - DATA: samples each bit at mid-bit, every `CLKS_PER_BIT` cycles.
  - STOP: samples at mid-bit. 1 → valid byte to `LEDR[7:0]`; 0 → set `LEDR[8]`, data discarded.
  - DONE: lasts one cycle, pulses `rx_done`, then → IDLE.
- The receiver is always active. `rx_done` only advances the sequencer in WAIT_RX.
- `LEDR[8]` clears only on reset.

## Timing
- Reset values:
  - `is_state`=0, rx state=0.
  - TX line = 1.
  - `LEDR`=0.
  - All counters 0.
- Reset asserted mid-frame aborts immediately. TX returns high the same cycle (asynchronous).
- Start latency: from `KEY[2]` falling to TX going low is 4 cycles (2 synchronizer, IDLE→LOAD_HDR, LOAD_HDR→SEND_HDR).
- Frame time: 3 × 10 × `CLKS_PER_BIT` cycles, plus 2 cycles between bytes (the LOAD states).
- RX enters START 2–3 cycles after the RX line falls.
- `LEDR[7:0]` updates in the same cycle the rx state enters DONE.

## Configuration
- `UART_PARITY_EN`:
  - Defined: frames are 8E1. An even-parity bit is inserted after D7 on TX. RX adds a PARITY state (encoding 5) between DATA and STOP. A parity mismatch sets `LEDR[8]` and discards the byte.
  - Undefined: 8N1 as above, and rx state 5 is unused.

## Test plan
- Reset: hold `KEY[0]`=0 → `GPIO[0]`=1, `is_state`=0, `LEDR`=0.
- Send: `CLKS_PER_BIT`=8, `SW`=8, `KEY[2]`=0 → TX carries bytes 0xA5, 0x08, 0xAD, each bit exactly 8 cycles; `is_state` reaches 7 and `LEDR[9]` falls.
- Reply: in WAIT_RX, drive byte 0x06 on `GPIO[1]` → rx state becomes 1 within 3 cycles of the falling edge; `LEDR[7:0]`=0x06; `is_state` returns to 0 (then back to 1 if `KEY[2]` is still held).
- Glitch: pull RX low for 2 cycles (`CLKS_PER_BIT`=8) → rx state goes 1 then back to 0; `LEDR` unchanged.
- Framing error: send 0x3C with the stop bit forced to 0 → `LEDR[8]`=1, `LEDR[7:0]` unchanged, `is_state` stays 7.
- Mid-frame reset: assert `KEY[0]` during SEND_DATA → TX=1 and `is_state`=0 at once; no further bits are sent after release until a new start request.
